l1ca_snapshot_buffer: RTL and testbench

Upstream stage of the L1 C/A coarse and fine search engines. It synchronises the raw 1-bit `signal_in`, records a fixed-length snapshot of samples into on-chip RAM, and replays that snapshot bit-serially into the search engines. Every Doppler/code bin is then correlated against identical data. When no replay is active, it passes live samples straight through.

---
 rtl/common_gnss_types_pkg.sv | 18 +
 rtl/snapshot_ram.sv | 32 +++
 rtl/l1ca_snapshot_buffer.sv | 235 +++++++++++++++++++++++
 tb/tb_l1ca_snapshot_buffer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_gnss_types_pkg.sv
// Types and constants shared by the GNSS front-end blocks (snapshot buffer and search engines).
package common_gnss_types_pkg;

  localparam int SNAP_WORD_W      = 32;
  localparam int SNAP_DEPTH_WORDS = 2048;

  // Word address for a snapshot RAM of the default depth.
  typedef logic [$clog2(SNAP_DEPTH_WORDS)-1:0] snap_addr_t;

  typedef enum logic [2:0] {
    SNAP_IDLE    = 3'd0,
    SNAP_CAPTURE = 3'd1,
    SNAP_READY   = 3'd2,
    SNAP_PRIME   = 3'd3,
    SNAP_REPLAY  = 3'd4
  } snap_state_t;

endpackage

// File: rtl/snapshot_ram.sv
// Single-port snapshot RAM, DEPTH_WORDS x 32, synchronous write, 1-cycle registered read.
module snapshot_ram
  import common_gnss_types_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                   gnssclk,
  input  logic                   en,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [SNAP_WORD_W-1:0] wdata,
  output logic [SNAP_WORD_W-1:0] rdata
);

  logic [SNAP_WORD_W-1:0] mem [DEPTH_WORDS];
  logic [SNAP_WORD_W-1:0] rdata_q;

  // No reset on the read register so the array maps onto block RAM.
  always_ff @(posedge gnssclk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/l1ca_snapshot_buffer.sv
// L1 C/A snapshot buffer: captures 1-bit samples into RAM and replays them bit-serially.
// SNAPSHOT_SYNC_EN selects the 2-flop synchroniser on signal_in; otherwise it is bypassed.
module l1ca_snapshot_buffer
  import common_gnss_types_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic          gnssclk,
  input  logic          nrst,
  input  logic          signal_in,
  input  logic          sample_en,
  input  logic          capture_start,
  input  logic [ADDR_W:0] capture_len,
  input  logic          replay_start,
  input  logic          replay_loop,
  input  logic          abort,
  output logic          sample_out,
  output logic          sample_valid,
  output logic          busy,
  output logic          snap_valid,
  output logic          capture_done,
  output logic          replay_done,
  output snap_state_t   dbg_state
);

  localparam int BIT_W = $clog2(SNAP_WORD_W);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(SNAP_WORD_W - 1);
  localparam logic [BIT_W-1:0]  BIT_MID  = BIT_W'(SNAP_WORD_W / 2);
  localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(DEPTH_WORDS);

  logic live_s;

`ifdef SNAPSHOT_SYNC_EN
  logic sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = signal_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge gnssclk) begin
    if (!nrst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign live_s = sync2_q;
`else
  assign live_s = signal_in;
`endif

  snap_state_t            state_q, state_d;
  logic [ADDR_W:0]        len_q, len_d;
  logic [ADDR_W-1:0]      waddr_q, waddr_d;
  logic [ADDR_W-1:0]      raddr_q, raddr_d;
  logic [BIT_W-1:0]       bitcnt_q, bitcnt_d;
  logic [SNAP_WORD_W-1:0] shreg_q, shreg_d;
  logic [SNAP_WORD_W-1:0] oword_q, oword_d;
  logic                   prime_q, prime_d;
  logic                   snap_valid_q, snap_valid_d;
  logic                   capture_done_q, capture_done_d;
  logic                   replay_done_q, replay_done_d;
  logic                   sample_out_q, sample_out_d;
  logic                   sample_valid_q, sample_valid_d;

  logic                   ram_en, ram_we;
  logic [ADDR_W-1:0]      ram_addr;
  logic [SNAP_WORD_W-1:0] ram_wdata, ram_rdata;
  logic [SNAP_WORD_W-1:0] cap_word;
  logic [ADDR_W-1:0]      raddr_next;
  logic [ADDR_W:0]        eff_len;
  logic                   last_cap, last_rep;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    waddr_d        = waddr_q;
    raddr_d        = raddr_q;
    bitcnt_d       = bitcnt_q;
    shreg_d        = shreg_q;
    oword_d        = oword_q;
    prime_d        = prime_q;
    snap_valid_d   = snap_valid_q;
    capture_done_d = 1'b0;
    replay_done_d  = 1'b0;
    ram_en         = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = raddr_q;
    cap_word       = shreg_q;
    cap_word[bitcnt_q] = live_s;
    ram_wdata      = cap_word;
    eff_len        = (capture_len == '0 || capture_len > LEN_MAX) ? LEN_MAX : capture_len;
    last_cap       = ({1'b0, waddr_q} + LEN_ONE) == len_q;
    last_rep       = ({1'b0, raddr_q} + LEN_ONE) == len_q;
    raddr_next     = last_rep ? '0 : raddr_q + ADDR_ONE;

    sample_valid_d = sample_en && (state_q != SNAP_PRIME);
    sample_out_d   = (state_q == SNAP_REPLAY) ? oword_q[bitcnt_q] : live_s;

    if (abort) begin
      // A stored snapshot survives an abort only from READY or REPLAY.
      if (state_q == SNAP_READY || state_q == SNAP_REPLAY) begin
        state_d = SNAP_READY;
      end else begin
        state_d      = SNAP_IDLE;
        snap_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        SNAP_IDLE, SNAP_READY: begin
          if (capture_start) begin
            state_d      = SNAP_CAPTURE;
            waddr_d      = '0;
            bitcnt_d     = '0;
            snap_valid_d = 1'b0;
            len_d        = eff_len;
          end else if (replay_start && snap_valid_q) begin
            state_d  = SNAP_PRIME;
            raddr_d  = '0;
            bitcnt_d = '0;
            prime_d  = 1'b1;
          end
        end
        SNAP_CAPTURE: begin
          if (sample_en) begin
            shreg_d  = cap_word;
            bitcnt_d = bitcnt_q + BIT_ONE;
            if (bitcnt_q == BIT_LAST) begin
              ram_en   = 1'b1;
              ram_we   = 1'b1;
              ram_addr = waddr_q;
              waddr_d  = waddr_q + ADDR_ONE;
              if (last_cap) begin
                capture_done_d = 1'b1;
                snap_valid_d   = 1'b1;
                state_d        = SNAP_READY;
              end
            end
          end
        end
        SNAP_PRIME: begin
          if (prime_q) begin
            ram_en  = 1'b1;
            prime_d = 1'b0;
          end else begin
            oword_d = ram_rdata;
            state_d = SNAP_REPLAY;
          end
        end
        SNAP_REPLAY: begin
          if (sample_en) begin
            bitcnt_d = bitcnt_q + BIT_ONE;
            // Prefetch at mid-word; the RAM output holds until the word is swapped in at bit 31.
            if (bitcnt_q == BIT_MID) begin
              ram_en   = 1'b1;
              ram_addr = raddr_next;
            end
            if (bitcnt_q == BIT_LAST) begin
              if (last_rep && !replay_loop) begin
                replay_done_d = 1'b1;
                state_d       = SNAP_READY;
              end else begin
                oword_d = ram_rdata;
                raddr_d = raddr_next;
              end
            end
          end
        end
        default: state_d = SNAP_IDLE;
      endcase
    end
  end

  always_ff @(posedge gnssclk) begin
    if (!nrst) begin
      state_q        <= SNAP_IDLE;
      len_q          <= '0;
      waddr_q        <= '0;
      raddr_q        <= '0;
      bitcnt_q       <= '0;
      shreg_q        <= '0;
      oword_q        <= '0;
      prime_q        <= 1'b0;
      snap_valid_q   <= 1'b0;
      capture_done_q <= 1'b0;
      replay_done_q  <= 1'b0;
      sample_out_q   <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      waddr_q        <= waddr_d;
      raddr_q        <= raddr_d;
      bitcnt_q       <= bitcnt_d;
      shreg_q        <= shreg_d;
      oword_q        <= oword_d;
      prime_q        <= prime_d;
      snap_valid_q   <= snap_valid_d;
      capture_done_q <= capture_done_d;
      replay_done_q  <= replay_done_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  snapshot_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .gnssclk (gnssclk),
    .en      (ram_en),
    .we      (ram_we),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign busy         = (state_q == SNAP_CAPTURE) || (state_q == SNAP_PRIME) ||
                        (state_q == SNAP_REPLAY);
  assign snap_valid   = snap_valid_q;
  assign capture_done = capture_done_q;
  assign replay_done  = replay_done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_l1ca_snapshot_buffer.sv
// Bench for l1ca_snapshot_buffer: random stimulus against a bit-queue model of the snapshot.
module tb_l1ca_snapshot_buffer;
  import common_gnss_types_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam int HIST  = 32768;
`ifdef SNAPSHOT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        gnssclk = 1'b0;
  logic        nrst, signal_in, sample_en, capture_start, replay_start, replay_loop, abort;
  logic [AW:0] capture_len;
  logic        sample_out, sample_valid, busy, snap_valid, capture_done, replay_done;
  snap_state_t dbg_state;

  l1ca_snapshot_buffer #(.DEPTH_WORDS(DEPTH)) dut (
    .gnssclk       (gnssclk),
    .nrst          (nrst),
    .signal_in     (signal_in),
    .sample_en     (sample_en),
    .capture_start (capture_start),
    .capture_len   (capture_len),
    .replay_start  (replay_start),
    .replay_loop   (replay_loop),
    .abort         (abort),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .snap_valid    (snap_valid),
    .capture_done  (capture_done),
    .replay_done   (replay_done),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 gnssclk = ~gnssclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- model state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  bit         sig_hist [HIST];
  bit         snap_bits [$];   // expected snapshot, in sample order
  logic [9:0] prn_q = 10'h3FF;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Live sample seen by the block in cycle c.
  function automatic bit exp_live(input int c);
    if (c - (LAT - 1) < 0) return 1'b0;
    return sig_hist[c - (LAT - 1)];
  endfunction

  function automatic bit src_bit(input int mode);
    bit b;
    if (mode == 1) begin
      b     = prn_q[9];
      prn_q = {prn_q[8:0], prn_q[2] ^ prn_q[9]};
      return b;
    end
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit en_bit(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return (i % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit sig, input bit en, input bit cs, input bit rs, input bit ab);
    signal_in     = sig;
    sample_en     = en;
    capture_start = cs;
    replay_start  = rs;
    abort         = ab;
    if (cyc < HIST) sig_hist[cyc] = sig;
    @(posedge gnssclk);
    @(negedge gnssclk);
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out"}, sample_out, 0);
    check_eq({tag, "_valid"}, sample_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_snap"}, snap_valid, 0);
    check_eq({tag, "_cdone"}, capture_done, 0);
    check_eq({tag, "_rdone"}, replay_done, 0);
    check_eq({tag, "_state"}, dbg_state, SNAP_IDLE);
  endtask

  task automatic passthru(input int n, input string tag);
    bit en;
    for (int i = 0; i < n; i++) begin
      en = 1'($urandom_range(0, 1));
      step(src_bit(0), en, 1'b0, 1'b0, 1'b0);
      check_eq({tag, "_live"}, sample_out, exp_live(cyc - 1));
      check_eq({tag, "_valid"}, sample_valid, en);
    end
  endtask

  task automatic do_capture(input int len_in, input int en_mode, input int src,
                            input int abort_at, input bit with_rs);
    int eff, total, consumed, done_cnt, i;
    bit en, sig;
    eff         = (len_in == 0 || len_in > DEPTH) ? DEPTH : len_in;
    total       = eff * 32;
    capture_len = len_in[AW:0];
    step(src_bit(src), 1'b1, 1'b1, with_rs, 1'b0);
    check_eq("cap_state", dbg_state, SNAP_CAPTURE);
    check_eq("cap_busy", busy, 1);
    check_eq("cap_snap_clr", snap_valid, 0);
    snap_bits.delete();
    consumed = 0;
    done_cnt = 0;
    i        = 0;
    while (consumed < total) begin
      en  = en_bit(en_mode, i);
      sig = src_bit(src);
      i++;
      if (consumed == abort_at) begin
        step(sig, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("cap_abort_state", dbg_state, SNAP_IDLE);
        check_eq("cap_abort_snap", snap_valid, 0);
        check_eq("cap_abort_busy", busy, 0);
        check_eq("cap_abort_done", capture_done, 0);
        snap_bits.delete();
        return;
      end
      step(sig, en, 1'b0, ($urandom_range(0, 15) == 0), 1'b0);
      if (en) begin
        snap_bits.push_back(exp_live(cyc - 1));
        consumed++;
      end
      if (capture_done) done_cnt++;
      check_eq("cap_done", capture_done, (en && consumed == total));
      check_eq("cap_live", sample_out, exp_live(cyc - 1));
      check_eq("cap_valid", sample_valid, en);
    end
    check_eq("cap_done_cnt", done_cnt, 1);
    check_eq("cap_end_state", dbg_state, SNAP_READY);
    check_eq("cap_end_snap", snap_valid, 1);
    check_eq("cap_end_busy", busy, 0);
  endtask

  task automatic do_replay(input bit loop, input int en_mode, input int n_valid,
                           input int reset_at);
    int total, idx, i;
    bit en;
    total       = snap_bits.size();
    replay_loop = loop;
    en          = 1'($urandom_range(0, 1));
    step(src_bit(0), en, 1'b0, 1'b1, 1'b0);
    check_eq("rp_start_state", dbg_state, SNAP_PRIME);
    check_eq("rp_start_live", sample_out, exp_live(cyc - 1));
    check_eq("rp_start_valid", sample_valid, en);
    // Two cycles pass before the first replay bit can be consumed.
    for (int p = 0; p < 2; p++) begin
      step(src_bit(0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      check_eq("rp_prime_valid", sample_valid, 0);
      check_eq("rp_prime_busy", busy, 1);
    end
    idx = 0;
    i   = 0;
    while (idx < n_valid) begin
      en = en_bit(en_mode, i);
      i++;
      if (reset_at >= 0 && idx == reset_at) begin
        nrst = 1'b0;
        step(1'b0, en, 1'b0, 1'b0, 1'b0);
        check_reset_outputs("rp_rst");
        nrst = 1'b1;
        snap_bits.delete();
        return;
      end
      step(src_bit(0), en, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), 1'b0);
      if (en) begin
        check_eq("rp_bit", sample_out, snap_bits[idx % total]);
        check_eq("rp_valid", sample_valid, 1);
        idx++;
      end else begin
        check_eq("rp_gap_valid", sample_valid, 0);
      end
      check_eq("rp_done", replay_done, (!loop && en && idx == total));
    end
    if (loop) begin
      step(src_bit(0), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check_eq("rp_end_state", dbg_state, SNAP_READY);
    check_eq("rp_end_snap", snap_valid, 1);
    check_eq("rp_end_busy", busy, 0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    nrst = 1'b0; signal_in = 1'b0; sample_en = 1'b0; capture_start = 1'b0;
    replay_start = 1'b0; replay_loop = 1'b0; abort = 1'b0; capture_len = '0;

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0);
      check_reset_outputs("reset");
    end
    nrst = 1'b1;

    passthru(20, "idle");

    // No snapshot stored: replay_start does nothing.
    for (int i = 0; i < 3; i++) begin
      step(src_bit(0), 1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("norep_busy", busy, 0);
      check_eq("norep_state", dbg_state, SNAP_IDLE);
    end

    // 128-bit PRN capture, then exact replay and return to passthrough.
    for (int i = 0; i < LAT; i++) step(src_bit(1), 1'b0, 1'b0, 1'b0, 1'b0);
    do_capture(4, 0, 1, -1, 1'b0);
    do_replay(1'b0, 0, 128, -1);
    passthru(10, "post_rp");

    step(src_bit(0), 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("ready_abort_state", dbg_state, SNAP_READY);
    check_eq("ready_abort_snap", snap_valid, 1);

    do_replay(1'b1, 1, 300, -1);
    passthru(5, "post_loop");
    do_replay(1'b0, 2, 128, -1);

    // Recapture from READY with replay_start in the same cycle: capture wins.
    do_capture($urandom_range(1, 8), 2, 0, -1, 1'b1);
    do_replay(1'b1, 2, 2 * snap_bits.size() + 7, -1);

    do_capture(1, 2, 0, -1, 1'b0);
    do_replay(1'b1, 1, 100, -1);

    do_capture(8, 2, 0, 50, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(src_bit(0), 1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("post_abort_busy", busy, 0);
      check_eq("post_abort_state", dbg_state, SNAP_IDLE);
    end

    do_capture(0, 0, 0, -1, 1'b0);
    do_replay(1'b0, 0, DEPTH * 32, -1);

    do_capture(100, 2, 0, -1, 1'b0);
    do_replay(1'b0, 0, DEPTH * 32, 100);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    passthru(20, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
